// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layer compositor.
//   rgb12_t         : 12-bit {R,G,B} pixel, 4 bits per channel.
//   seg_t           : one solid-rectangle entry {x0, y0, w, h, rgb}, 52 bits.
//   DEFAULT_KEY_RGB : default transparent color for sprite pixels.
//   in_span()       : start <= pos < start+len, evaluated in 11 bits so that
//                     boxes near 1023 never wrap into column/row 0.
package compositor_pkg;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] w;
        logic [9:0] h;
        rgb12_t     rgb;
    } seg_t;

    localparam rgb12_t DEFAULT_KEY_RGB = 12'h0F1;

    // A zero length gives an empty span, which is what disables a segment
    // entry with w==0 or h==0.
    function automatic logic in_span(input logic [9:0] pos,
                                     input logic [9:0] start,
                                     input logic [9:0] len);
        logic [10:0] p;
        logic [10:0] lo;
        logic [10:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, start};
        hi = lo + {1'b0, len};
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Per-layer sprite box test, registered one cycle after the pixel.
// Ports:
//   Clk, Reset      : pixel clock, synchronous active-high reset
//   en              : layer enable
//   draw_x, draw_y  : current pixel
//   pos_x, pos_y    : sprite top-left corner
//   mirror          : mirror the column address horizontally
//   hit             : registered hit flag
//   ax, ay          : registered local ROM address (0 on a miss)
module sprite_hit
    import compositor_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      en,
    input  logic [9:0]                draw_x,
    input  logic [9:0]                draw_y,
    input  logic [9:0]                pos_x,
    input  logic [9:0]                pos_y,
    input  logic                      mirror,
    output logic                      hit,
    output logic [$clog2(SPR_W)-1:0]  ax,
    output logic [$clog2(SPR_H)-1:0]  ay
);

    localparam int AW = $clog2(SPR_W);
    localparam int AH = $clog2(SPR_H);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;

    assign dx     = draw_x - pos_x;
    assign dy     = draw_y - pos_y;
    assign in_box = en && in_span(draw_x, pos_x, 10'(SPR_W))
                       && in_span(draw_y, pos_y, 10'(SPR_H));

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit <= 1'b0;
            ax  <= '0;
            ay  <= '0;
        end else if (in_box) begin
            hit <= 1'b1;
            // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse.
            ax  <= mirror ? ~dx[AW-1:0] : dx[AW-1:0];
            ay  <= dy[AH-1:0];
        end else begin
            hit <= 1'b0;
            ax  <= '0;
            ay  <= '0;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Per-pixel compositor: segment table over N_SPR sprite layers over background.
// Fixed 3-cycle latency from DrawX/DrawY/vde to Red/Green/Blue/vde_out.
// Optional feature macro: LAYER_COMPOSITOR_FACING_EN (layer 0 mirroring).
// Ports:
//   Clk, Reset          : pixel clock, synchronous active-high reset
//   vde, frame_start    : data enable, first-pixel-of-frame pulse
//   DrawX, DrawY        : current pixel
//   spr_en/spr_x/spr_y  : per-layer enable and top-left corner (packed)
//   go_left, go_right   : facing request for layer 0
//   spr_ax, spr_ay      : per-layer sprite ROM address (packed)
//   spr_rgb, bg_rgb     : ROM pixels and background, valid two cycles later
//   seg_we/idx/data     : shadow segment table write port
//   Red/Green/Blue      : composed pixel; vde_out: vde aligned with it
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int     N_SPR   = 4,
    parameter int     SPR_W   = 32,
    parameter int     SPR_H   = 32,
    parameter int     N_SEG   = 16,
    parameter rgb12_t KEY_RGB = DEFAULT_KEY_RGB
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             vde,
    input  logic                             frame_start,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic [N_SPR-1:0]                 spr_en,
    input  logic [N_SPR*10-1:0]              spr_x,
    input  logic [N_SPR*10-1:0]              spr_y,
    input  logic                             go_left,
    input  logic                             go_right,
    output logic [N_SPR*$clog2(SPR_W)-1:0]   spr_ax,
    output logic [N_SPR*$clog2(SPR_H)-1:0]   spr_ay,
    input  logic [N_SPR*12-1:0]              spr_rgb,
    input  logic [11:0]                      bg_rgb,
    input  logic                             seg_we,
    input  logic [$clog2(N_SEG)-1:0]         seg_idx,
    input  logic [51:0]                      seg_data,
    output logic [3:0]                       Red,
    output logic [3:0]                       Green,
    output logic [3:0]                       Blue,
    output logic                             vde_out
);

    localparam int AW = $clog2(SPR_W);
    localparam int AH = $clog2(SPR_H);

    seg_t shadow [N_SEG];
    seg_t active [N_SEG];

    logic facing;

    // ---------------- segment tables ----------------
    // NOTE: both tables are reset because a cleared entry (w==0) is how an
    // entry is disabled; an uninitialised table would draw garbage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int j = 0; j < N_SEG; j++) begin
                shadow[j] <= '0;
                active[j] <= '0;
            end
        end else begin
            if (seg_we)
                shadow[seg_idx] <= seg_t'(seg_data);
            // Copies the pre-write shadow when seg_we coincides.
            if (frame_start)
                active <= shadow;
        end
    end

    // ---------------- facing ----------------
`ifdef LAYER_COMPOSITOR_FACING_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            facing <= 1'b0;
        else if (frame_start) begin
            if (go_left && !go_right)
                facing <= 1'b1;
            else if (go_right && !go_left)
                facing <= 1'b0;
        end
    end
`else
    logic unused_facing_req;
    assign unused_facing_req = go_left ^ go_right;
    assign facing            = 1'b0;
`endif

    // ---------------- stage 1: hit detection ----------------
    logic [N_SPR-1:0] spr_hit1;

    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
        sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
            .Clk    (Clk),
            .Reset  (Reset),
            .en     (spr_en[i]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .pos_x  (spr_x[i*10 +: 10]),
            .pos_y  (spr_y[i*10 +: 10]),
            .mirror ((i == 0) ? facing : 1'b0),
            .hit    (spr_hit1[i]),
            .ax     (spr_ax[i*AW +: AW]),
            .ay     (spr_ay[i*AH +: AH])
        );
    end

    logic   seg_hit_c;
    rgb12_t seg_rgb_c;

    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred. Descending scan leaves the lowest-index hit as winner.
    always_comb begin
        seg_hit_c = 1'b0;
        seg_rgb_c = '0;
        for (int j = N_SEG - 1; j >= 0; j--) begin
            if (in_span(DrawX, active[j].x0, active[j].w) &&
                in_span(DrawY, active[j].y0, active[j].h)) begin
                seg_hit_c = 1'b1;
                seg_rgb_c = active[j].rgb;
            end
        end
    end

    logic   seg_hit1, vde1;
    rgb12_t seg_rgb1;

    // ---------------- stage 2: wait for ROM data ----------------
    logic [N_SPR-1:0] spr_hit2;
    logic             seg_hit2, vde2;
    rgb12_t           seg_rgb2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            seg_hit1 <= 1'b0;
            seg_rgb1 <= '0;
            vde1     <= 1'b0;
            spr_hit2 <= '0;
            seg_hit2 <= 1'b0;
            seg_rgb2 <= '0;
            vde2     <= 1'b0;
        end else begin
            seg_hit1 <= seg_hit_c;
            seg_rgb1 <= seg_rgb_c;
            vde1     <= vde;
            spr_hit2 <= spr_hit1;
            seg_hit2 <= seg_hit1;
            seg_rgb2 <= seg_rgb1;
            vde2     <= vde1;
        end
    end

    // ---------------- priority select ----------------
    rgb12_t pix;

    always_comb begin
        pix = bg_rgb;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (spr_hit2[i] && (spr_rgb[i*12 +: 12] != KEY_RGB))
                pix = spr_rgb[i*12 +: 12];
        end
        if (seg_hit2)
            pix = seg_rgb2;
        if (!vde2)
            pix = '0;
    end

    // ---------------- stage 3: output register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            {Red, Green, Blue} <= '0;
            vde_out            <= 1'b0;
        end else begin
            {Red, Green, Blue} <= pix;
            vde_out            <= vde2;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (default parameters).
// Table-driven steady-state vectors plus hand-written multi-cycle sequences
// for reset, latency, segment commit and (if enabled) sprite mirroring.
module tb_layer_compositor;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          vde, frame_start;
    logic [9:0]    DrawX, DrawY;
    logic [3:0]    spr_en;
    logic [39:0]   spr_x, spr_y;
    logic          go_left, go_right;
    logic [19:0]   spr_ax, spr_ay;
    logic [47:0]   spr_rgb;
    logic [11:0]   bg_rgb;
    logic          seg_we;
    logic [3:0]    seg_idx;
    logic [51:0]   seg_data;
    logic [3:0]    Red, Green, Blue;
    logic          vde_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    layer_compositor dut (
        .Clk(Clk), .Reset(Reset), .vde(vde), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .go_left(go_left), .go_right(go_right),
        .spr_ax(spr_ax), .spr_ay(spr_ay), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
        .seg_we(seg_we), .seg_idx(seg_idx), .seg_data(seg_data),
        .Red(Red), .Green(Green), .Blue(Blue), .vde_out(vde_out)
    );

    typedef struct {
        logic        vde;
        logic [3:0]  en;
        logic [9:0]  x0, y0, x1, y1, px, py;
        logic [11:0] r0, r1, bg, exp_rgb;
        logic [4:0]  exp_ax;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic v, input logic [3:0] en,
                                input logic [9:0] x0, y0, x1, y1, px, py,
                                input logic [11:0] r0, r1, bg, e,
                                input logic [4:0] eax);
        vec_t t;
        t.vde = v; t.en = en; t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1;
        t.px = px; t.py = py; t.r0 = r0; t.r1 = r1; t.bg = bg;
        t.exp_rgb = e; t.exp_ax = eax;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic seg_write(input logic [3:0] idx, input logic [9:0] x0, y0,
                             w, h, input logic [11:0] rgb, input logic fs);
        seg_we      = 1'b1;
        seg_idx     = idx;
        seg_data    = {x0, y0, w, h, rgb};
        frame_start = fs;
        tick(1);
        seg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic px_check(input string name, input logic [9:0] x, y,
                            input logic [11:0] exp);
        DrawX = x;
        DrawY = y;
        tick(4);
        check(name, {Red, Green, Blue}, exp);
    endtask

    task automatic set_spr0(input logic [9:0] x, y);
        spr_x[9:0] = x;
        spr_y[9:0] = y;
    endtask

    initial begin
        Reset = 1'b1; vde = 1'b1; frame_start = 1'b0;
        DrawX = 10'd5; DrawY = 10'd5; spr_en = 4'b0000;
        spr_x = '0; spr_y = '0; go_left = 1'b0; go_right = 1'b0;
        spr_rgb = '0; bg_rgb = 12'h123;
        seg_we = 1'b0; seg_idx = '0; seg_data = '0;

        vecs[0]  = mk(1, 4'b0001, 100, 50, 110, 60, 100, 50, 12'hABC, 12'h555, 12'h123, 12'hABC, 0);
        vecs[1]  = mk(1, 4'b0001, 100, 50, 110, 60, 132, 50, 12'hABC, 12'h555, 12'h123, 12'h123, 0);
        vecs[2]  = mk(1, 4'b0001, 100, 50, 110, 60, 131, 81, 12'hABC, 12'h555, 12'h123, 12'hABC, 31);
        vecs[3]  = mk(1, 4'b0001, 100, 50, 110, 60, 131, 82, 12'hABC, 12'h555, 12'h123, 12'h123, 0);
        vecs[4]  = mk(1, 4'b0011, 100, 50, 110, 60, 115, 65, 12'h0F1, 12'h555, 12'h123, 12'h555, 15);
        vecs[5]  = mk(1, 4'b0001, 100, 50, 110, 60, 115, 65, 12'h0F1, 12'h555, 12'h123, 12'h123, 15);
        vecs[6]  = mk(1, 4'b0011, 100, 50, 110, 60, 115, 65, 12'hABC, 12'h555, 12'h123, 12'hABC, 15);
        vecs[7]  = mk(1, 4'b0010, 100, 50, 110, 60, 115, 65, 12'hABC, 12'h555, 12'h123, 12'h555, 0);
        vecs[8]  = mk(0, 4'b0011, 100, 50, 110, 60, 115, 65, 12'hABC, 12'h555, 12'h123, 12'h000, 15);
        vecs[9]  = mk(1, 4'b0001, 1010, 50, 110, 60, 5, 50, 12'hABC, 12'h555, 12'h123, 12'h123, 0);
        vecs[10] = mk(1, 4'b0001, 1010, 50, 110, 60, 1015, 50, 12'hABC, 12'h555, 12'h123, 12'hABC, 5);
        vecs[11] = mk(1, 4'b0001, 100, 1010, 110, 60, 100, 3, 12'hABC, 12'h555, 12'h123, 12'h123, 0);
        vecs[12] = mk(1, 4'b0011, 100, 50, 110, 60, 115, 65, 12'h0F1, 12'h0F1, 12'h123, 12'h123, 15);

        // ---- reset and release ----
        tick(3);
        check("reset_rgb", {Red, Green, Blue}, 12'h000);
        check("reset_vde_out", vde_out, 1'b0);
        check("reset_ax", spr_ax, 20'h0);
        Reset = 1'b0;
        tick(1);
        check("post_reset_c1", {Red, Green, Blue}, 12'h000);
        tick(1);
        check("post_reset_c2", {Red, Green, Blue}, 12'h000);
        tick(1);
        check("post_reset_c3", {Red, Green, Blue}, 12'h123);
        check("post_reset_vde", vde_out, 1'b1);

        // ---- table-driven steady-state vectors ----
        for (int k = 0; k < 13; k++) begin
            vde     = vecs[k].vde;
            spr_en  = vecs[k].en;
            spr_x   = {10'd0, 10'd0, vecs[k].x1, vecs[k].x0};
            spr_y   = {10'd0, 10'd0, vecs[k].y1, vecs[k].y0};
            spr_rgb = {12'h000, 12'h000, vecs[k].r1, vecs[k].r0};
            bg_rgb  = vecs[k].bg;
            DrawX   = vecs[k].px;
            DrawY   = vecs[k].py;
            tick(4);
            check($sformatf("vec%0d_rgb", k), {Red, Green, Blue}, vecs[k].exp_rgb);
            check($sformatf("vec%0d_vde", k), vde_out, vecs[k].vde);
            check($sformatf("vec%0d_ax0", k), spr_ax[4:0], vecs[k].exp_ax);
        end

        // ---- latency: hit appears at t+1 on the address, t+3 on the pixel ----
        vde = 1'b1; spr_en = 4'b0001; set_spr0(100, 50);
        spr_rgb = {36'h0, 12'hABC}; bg_rgb = 12'h123;
        px_check("lat_pre", 132, 50, 12'h123);
        DrawX = 10'd105; DrawY = 10'd52;
        tick(1);
        check("lat_ax_t1", spr_ax[4:0], 5'd5);
        check("lat_ay_t1", spr_ay[4:0], 5'd2);
        check("lat_rgb_t1", {Red, Green, Blue}, 12'h123);
        tick(1);
        check("lat_rgb_t2", {Red, Green, Blue}, 12'h123);
        tick(1);
        check("lat_rgb_t3", {Red, Green, Blue}, 12'hABC);

        // ---- segment double buffering ----
        set_spr0(0, 390);
        px_check("seg_pre", 10, 402, 12'hABC);
        seg_write(4'd3, 10'd0, 10'd400, 10'd640, 10'd5, 12'hC70, 1'b0);
        px_check("seg_uncommitted", 10, 402, 12'hABC);
        pulse_frame();
        px_check("seg_committed", 10, 402, 12'hC70);
        px_check("seg_right_edge", 639, 404, 12'hC70);
        px_check("seg_x_past", 640, 404, 12'h123);
        px_check("seg_y_past", 10, 405, 12'hABC);
        px_check("seg_y_before", 10, 399, 12'hABC);

        px_check("coin_pre", 205, 105, 12'h123);
        seg_write(4'd5, 10'd200, 10'd100, 10'd10, 10'd10, 12'h0F0, 1'b1);
        px_check("coin_same_frame", 205, 105, 12'h123);
        pulse_frame();
        px_check("coin_next_frame", 205, 105, 12'h0F0);

        seg_write(4'd4, 10'd200, 10'd100, 10'd5, 10'd5, 12'h00F, 1'b0);
        seg_write(4'd1, 10'd0, 10'd0, 10'd0, 10'd10, 12'hFFF, 1'b0);
        seg_write(4'd2, 10'd0, 10'd0, 10'd10, 10'd0, 12'hEEE, 1'b0);
        pulse_frame();
        px_check("seg_low_index_wins", 202, 102, 12'h00F);
        px_check("seg_outside_low", 207, 107, 12'h0F0);
        px_check("seg_zero_wh", 5, 5, 12'h123);

        // ---- mid-frame reset flushes pipeline and clears tables ----
        DrawX = 10'd10; DrawY = 10'd402;
        tick(4);
        Reset = 1'b1;
        tick(2);
        check("midreset_rgb", {Red, Green, Blue}, 12'h000);
        Reset = 1'b0;
        tick(1);
        check("midreset_c1", {Red, Green, Blue}, 12'h000);
        tick(1);
        check("midreset_c2", {Red, Green, Blue}, 12'h000);
        tick(1);
        check("midreset_c3", {Red, Green, Blue}, 12'hABC);
        pulse_frame();
        px_check("shadow_cleared", 10, 402, 12'hABC);

`ifdef LAYER_COMPOSITOR_FACING_EN
        // ---- layer 0 mirroring follows go_left at the next frame ----
        set_spr0(100, 50);
        DrawX = 10'd100; DrawY = 10'd50;
        go_left = 1'b1;
        tick(3);
        check("facing_before_frame", spr_ax[4:0], 5'd0);
        pulse_frame();
        go_left = 1'b0;
        tick(2);
        check("facing_mirrored", spr_ax[4:0], 5'd31);
        DrawX = 10'd131;
        tick(2);
        check("facing_mirrored_end", spr_ax[4:0], 5'd0);
        go_left = 1'b1; go_right = 1'b1;
        pulse_frame();
        go_left = 1'b0; go_right = 1'b0;
        tick(2);
        check("facing_both_hold", spr_ax[4:0], 5'd0);
        go_right = 1'b1;
        pulse_frame();
        go_right = 1'b0;
        tick(2);
        check("facing_right", spr_ax[4:0], 5'd31);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
